// File: rtl/tlb_pkg.sv
// Shared types and constants for the fully associative TLB.
// Entry fields are sized to maxima so the struct can live in a package.
package tlb_pkg;
   localparam int VPN_MAX_W  = 64;
   localparam int PPN_MAX_W  = 64;
   localparam int ASID_MAX_W = 16;

   localparam int PTE_R = 0;
   localparam int PTE_W = 1;
   localparam int PTE_G = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_PTW_REQ,
      S_PTW_WAIT,
      S_RESP
   } tlb_state_e;

   typedef struct packed {
      logic                  valid;
      logic [VPN_MAX_W-1:0]  vpn;
      logic [PPN_MAX_W-1:0]  ppn;
      logic                  r;
      logic                  w;
      logic                  g;
      logic [ASID_MAX_W-1:0] asid;
   } tlb_entry_t;

   function automatic logic perm_ok(input logic r, input logic w, input logic is_write);
      return is_write ? w : r;
   endfunction
endpackage

// File: rtl/tlb_cam.sv
// Parallel VPN (and, with TLB_ASID_EN, ASID/global) match across all entries.
// Produces one-hot hit vector, encoded index and any-hit flag.
module tlb_cam
   import tlb_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic [ENTRIES-1:0]                 valid_i,
   input  logic [ENTRIES-1:0][VPN_MAX_W-1:0]  vpn_i,
   input  logic [ENTRIES-1:0]                 g_i,
   input  logic [ENTRIES-1:0][ASID_MAX_W-1:0] asid_i,
   input  logic [VPN_MAX_W-1:0]               req_vpn_i,
   input  logic [ASID_MAX_W-1:0]              req_asid_i,
   output logic [ENTRIES-1:0]                 hit_vec_o,
   output logic [IDX_W-1:0]                   hit_idx_o,
   output logic                               any_hit_o
);

   for (genvar i = 0; i < ENTRIES; i++) begin : g_match
`ifdef TLB_ASID_EN
      assign hit_vec_o[i] = valid_i[i] && (vpn_i[i] == req_vpn_i) &&
                            (g_i[i] || (asid_i[i] == req_asid_i));
`else
      assign hit_vec_o[i] = valid_i[i] && (vpn_i[i] == req_vpn_i);
`endif
   end

`ifndef TLB_ASID_EN
   logic unused_asid;
   assign unused_asid = ^{g_i, asid_i, req_asid_i};
`endif

   // At most one entry can match, so OR-encoding the index is sufficient.
   always_comb begin
      hit_idx_o = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (hit_vec_o[i]) hit_idx_o = hit_idx_o | IDX_W'(i);
   end

   assign any_hit_o = |hit_vec_o;
endmodule

// File: rtl/tlb_assoc.sv
// Fully associative TLB with PTW refill, round-robin replacement, permission check
// and flush. Define TLB_ASID_EN to tag entries with an ASID and enable ASID flush.
module tlb_assoc
   import tlb_pkg::*;
#(
   parameter int ENTRIES   = 8,
   parameter int VA_W      = 32,
   parameter int PA_W      = 32,
   parameter int PAGE_BITS = 12,
   parameter int ASID_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [VA_W-1:0]   vaddr_i,
   input  logic              access_type_i,
   input  logic [ASID_W-1:0] asid_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [PA_W-1:0]   paddr_o,
   output logic              hit_o,
   output logic              fault_o,
   input  logic              flush_valid_i,
   input  logic              flush_asid_only_i,
   input  logic [ASID_W-1:0] flush_asid_i,
   output logic              ptw_req_valid_o,
   input  logic              ptw_req_ready_i,
   output logic [VA_W-1:0]   ptw_vaddr_o,
   input  logic              ptw_resp_valid_i,
   output logic              ptw_resp_ready_o,
   input  logic [PA_W-1:0]   ptw_pte_i
);
   localparam int IDX_W = $clog2(ENTRIES);

   tlb_state_e               state_q;
   tlb_entry_t [ENTRIES-1:0] ent_q;
   logic [IDX_W-1:0]         rr_q;
   logic [VA_W-1:0]          vaddr_q;
   logic                     wr_q;
   logic [ASID_MAX_W-1:0]    asid_q, asid_d;
   logic [PA_W-1:0]          paddr_q;
   logic                     hit_q, fault_q;

`ifdef TLB_ASID_EN
   assign asid_d = ASID_MAX_W'(asid_i);
`else
   assign asid_d = '0;
   logic unused_asid;
   assign unused_asid = ^{asid_i, flush_asid_i, flush_asid_only_i};
`endif

   // CAM view of the entry array
   logic [ENTRIES-1:0]                 valid_v, g_v, hit_vec;
   logic [ENTRIES-1:0][VPN_MAX_W-1:0]  vpn_v;
   logic [ENTRIES-1:0][ASID_MAX_W-1:0] asid_v;
   logic [VPN_MAX_W-1:0]               req_vpn;
   logic [IDX_W-1:0]                   hit_idx;
   logic                               any_hit;

   for (genvar i = 0; i < ENTRIES; i++) begin : g_view
      assign valid_v[i] = ent_q[i].valid;
      assign vpn_v[i]   = ent_q[i].vpn;
      assign g_v[i]     = ent_q[i].g;
      assign asid_v[i]  = ent_q[i].asid;
   end

   assign req_vpn = VPN_MAX_W'(vaddr_q[VA_W-1:PAGE_BITS]);

   tlb_cam #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cam (
      .valid_i   (valid_v),
      .vpn_i     (vpn_v),
      .g_i       (g_v),
      .asid_i    (asid_v),
      .req_vpn_i (req_vpn),
      .req_asid_i(asid_q),
      .hit_vec_o (hit_vec),
      .hit_idx_o (hit_idx),
      .any_hit_o (any_hit)
   );

   logic            hit_ok, fill_ok, pte_valid;
   logic [PA_W-1:0] hit_paddr, fill_paddr;
   logic            unused_misc;

   assign hit_ok     = perm_ok(ent_q[hit_idx].r, ent_q[hit_idx].w, wr_q);
   assign hit_paddr  = PA_W'({ent_q[hit_idx].ppn, vaddr_q[PAGE_BITS-1:0]});
   assign pte_valid  = ptw_pte_i[PTE_R] | ptw_pte_i[PTE_W];
   assign fill_ok    = perm_ok(ptw_pte_i[PTE_R], ptw_pte_i[PTE_W], wr_q);
   assign fill_paddr = {ptw_pte_i[PA_W-1:PAGE_BITS], vaddr_q[PAGE_BITS-1:0]};
   assign unused_misc = ^{ptw_pte_i[PAGE_BITS-1:3], hit_vec};

   tlb_entry_t fill_ent;
   always_comb begin
      fill_ent       = '0;
      fill_ent.valid = 1'b1;
      fill_ent.vpn   = req_vpn;
      fill_ent.ppn   = PPN_MAX_W'(ptw_pte_i[PA_W-1:PAGE_BITS]);
      fill_ent.r     = ptw_pte_i[PTE_R];
      fill_ent.w     = ptw_pte_i[PTE_W];
      fill_ent.g     = ptw_pte_i[PTE_G];
      fill_ent.asid  = asid_q;
   end

   // Lowest free slot wins; the round-robin pointer only matters when full.
   logic [IDX_W-1:0] victim;
   logic             have_free;
   always_comb begin
      victim    = rr_q;
      have_free = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!ent_q[i].valid) begin
            victim    = IDX_W'(i);
            have_free = 1'b1;
         end
   end

   logic [ENTRIES-1:0] flush_hit;
`ifdef TLB_ASID_EN
   always_comb begin
      flush_hit = '0;
      for (int i = 0; i < ENTRIES; i++)
         flush_hit[i] = !flush_asid_only_i ||
                        (!ent_q[i].g && (ent_q[i].asid == ASID_MAX_W'(flush_asid_i)));
   end
`else
   assign flush_hit = '1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ent_q   <= '0;
         rr_q    <= '0;
         vaddr_q <= '0;
         wr_q    <= 1'b0;
         asid_q  <= '0;
         paddr_q <= '0;
         hit_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:
               if (req_valid_i && !flush_valid_i) begin
                  vaddr_q <= vaddr_i;
                  wr_q    <= access_type_i;
                  asid_q  <= asid_d;
                  state_q <= S_LOOKUP;
               end
            S_LOOKUP:
               if (any_hit) begin
                  paddr_q <= hit_ok ? hit_paddr : '0;
                  hit_q   <= 1'b1;
                  fault_q <= !hit_ok;
                  state_q <= S_RESP;
               end else begin
                  state_q <= S_PTW_REQ;
               end
            S_PTW_REQ:
               if (ptw_req_ready_i) state_q <= S_PTW_WAIT;
            S_PTW_WAIT:
               if (ptw_resp_valid_i) begin
                  paddr_q <= fill_ok ? fill_paddr : '0;
                  hit_q   <= 1'b0;
                  fault_q <= !fill_ok;
                  state_q <= S_RESP;
                  // A coincident flush wins over the fill; the response still goes out.
                  if (pte_valid && !flush_valid_i) begin
                     ent_q[victim] <= fill_ent;
                     if (!have_free) rr_q <= rr_q + IDX_W'(1);
                  end
               end
            S_RESP:
               if (resp_ready_i) state_q <= S_IDLE;
            default:
               state_q <= S_IDLE;
         endcase
         if (flush_valid_i)
            for (int i = 0; i < ENTRIES; i++)
               if (flush_hit[i]) ent_q[i].valid <= 1'b0;
      end
   end

   assign req_ready_o      = (state_q == S_IDLE) && !flush_valid_i;
   assign resp_valid_o     = (state_q == S_RESP);
   assign ptw_req_valid_o  = (state_q == S_PTW_REQ);
   assign ptw_resp_ready_o = (state_q == S_PTW_WAIT);
   assign ptw_vaddr_o      = {vaddr_q[VA_W-1:PAGE_BITS], {PAGE_BITS{1'b0}}};
   assign paddr_o          = paddr_q;
   assign hit_o            = hit_q;
   assign fault_o          = fault_q;
endmodule

// File: tb/tb_tlb_assoc.sv
// Randomised scoreboard bench for tlb_assoc with a slot-level TLB model and a
// behavioural page-table walker; follows TLB_ASID_EN like the design.
`timescale 1ns/1ps
module tb_tlb_assoc;
   localparam int ENTRIES = 8;

   logic        clk, rst;
   logic        req_valid_i, req_ready_o, access_type_i;
   logic [31:0] vaddr_i;
   logic [7:0]  asid_i, flush_asid_i;
   logic        resp_valid_o, resp_ready_i, hit_o, fault_o;
   logic [31:0] paddr_o;
   logic        flush_valid_i, flush_asid_only_i;
   logic        ptw_req_valid_o, ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ready_o;
   logic [31:0] ptw_vaddr_o, ptw_pte_i;

   tlb_assoc #(.ENTRIES(ENTRIES), .VA_W(32), .PA_W(32), .PAGE_BITS(12), .ASID_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .vaddr_i(vaddr_i),
      .access_type_i(access_type_i), .asid_i(asid_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .paddr_o(paddr_o),
      .hit_o(hit_o), .fault_o(fault_o),
      .flush_valid_i(flush_valid_i), .flush_asid_only_i(flush_asid_only_i),
      .flush_asid_i(flush_asid_i),
      .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
      .ptw_vaddr_o(ptw_vaddr_o), .ptw_resp_valid_i(ptw_resp_valid_i),
      .ptw_resp_ready_o(ptw_resp_ready_o), .ptw_pte_i(ptw_pte_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   initial forever @(posedge clk) cyc++;

   int n_vec = 0, n_err = 0;
   int accept_cyc = 0;
   bit ptw_hold = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] paddr; logic hit; logic fault; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] walk_q[$];
   logic [31:0] pt [logic [19:0]];

   bit          m_valid[ENTRIES];
   logic [19:0] m_vpn[ENTRIES];
   logic [31:0] m_pte[ENTRIES];
   logic [7:0]  m_asid[ENTRIES];
   int          m_rr;

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_rr = 0;
   endtask

   function automatic int m_find(input logic [19:0] vpn, input logic [7:0] asid);
      for (int i = 0; i < ENTRIES; i++)
         if (m_valid[i] && m_vpn[i] == vpn) begin
`ifdef TLB_ASID_EN
            if (m_pte[i][2] || m_asid[i] == asid) return i;
`else
            return i;
`endif
         end
      return -1;
   endfunction

   task automatic m_install(input logic [19:0] vpn, input logic [31:0] pte, input logic [7:0] asid);
      int v = -1;
      for (int i = 0; i < ENTRIES; i++)
         if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) begin
         v = m_rr;
         m_rr = (m_rr + 1) % ENTRIES;
      end
      m_valid[v] = 1; m_vpn[v] = vpn; m_pte[v] = pte; m_asid[v] = asid;
   endtask

   task automatic m_flush(input bit only, input logic [7:0] fasid);
      for (int i = 0; i < ENTRIES; i++) begin
`ifdef TLB_ASID_EN
         if (!only || (!m_pte[i][2] && m_asid[i] == fasid)) m_valid[i] = 0;
`else
         m_valid[i] = 0;
`endif
      end
   endtask

   task automatic predict(input logic [31:0] va, input logic wr, input logic [7:0] asid);
      exp_t e;
      logic [31:0] pte;
      int idx = m_find(va[31:12], asid);
      bit ok;
      if (idx >= 0) begin
         pte = m_pte[idx];
         e.hit = 1;
      end else begin
         pte = pt[va[31:12]];
         e.hit = 0;
         walk_q.push_back({va[31:12], 12'h000});
         if (pte[1:0] != 2'b00) m_install(va[31:12], pte, asid);
      end
      ok = wr ? pte[1] : pte[0];
      e.fault = !ok;
      e.paddr = ok ? {pte[31:12], va[11:0]} : 32'h0;
      exp_q.push_back(e);
   endtask

   // ---------------- driver tasks (entered at posedge+1) ----------------
   task automatic access(input logic [31:0] va, input logic wr, input logic [7:0] asid,
                         input bit flush_first, input bit want_resp);
      int n;
      bit done;
      if (flush_first) m_flush(0, 8'h0);
      predict(va, wr, asid);
      vaddr_i = va; access_type_i = wr; asid_i = asid; req_valid_i = 1;
      if (flush_first) begin flush_valid_i = 1; flush_asid_only_i = 0; end
      done = 0; n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         if (flush_valid_i) chk("ready_during_flush", req_ready_o, 0);
         else if (req_ready_o) begin done = 1; accept_cyc = cyc; end
         @(posedge clk); #1;
         flush_valid_i = 0;
         n++;
      end
      req_valid_i = 0;
      if (!done) fail("req_accept");
      if (want_resp && done) begin
         done = 0; n = 0;
         while (!done && n < 200) begin
            resp_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (resp_valid_o && resp_ready_i) done = 1;
            @(posedge clk); #1;
            n++;
         end
         resp_ready_i = 0;
         if (!done) fail("resp_wait");
      end
   endtask

   task automatic do_flush(input bit only, input logic [7:0] fasid);
      flush_valid_i = 1; flush_asid_only_i = only; flush_asid_i = fasid;
      @(posedge clk); #1;
      flush_valid_i = 0;
      m_flush(only, fasid);
   endtask

   // ---------------- response monitor ----------------
   initial begin
      bit seen = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) seen = 0;
         else if (resp_valid_o) begin
            if (!seen) begin
               seen = 1;
               if (exp_q.size() > 0 && exp_q[0].hit) chk("hit_latency", cyc - accept_cyc, 2);
            end
            if (resp_ready_i) begin
               seen = 0;
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_resp: got paddr 0x%0h with no request pending", paddr_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("paddr", paddr_o, e.paddr);
                  chk("hit", hit_o, e.hit);
                  chk("fault", fault_o, e.fault);
               end
            end
         end
      end
   end

   // ---------------- page-table walker model ----------------
   initial begin
      bit req_hs, resp_hs, pending;
      int delay;
      logic [31:0] walk_va;
      ptw_req_ready_i = 0; ptw_resp_valid_i = 0; ptw_pte_i = 0;
      pending = 0; delay = 0; walk_va = 0;
      forever begin
         @(negedge clk);
         req_hs  = ptw_req_valid_o && ptw_req_ready_i && !rst;
         resp_hs = ptw_resp_valid_i && ptw_resp_ready_o && !rst;
         if (req_hs) begin
            if (walk_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_walk: got ptw_vaddr 0x%0h with none expected", ptw_vaddr_o);
            end else chk("ptw_vaddr", ptw_vaddr_o, walk_q.pop_front());
            walk_va = ptw_vaddr_o;
         end
         @(posedge clk); #1;
         if (rst) begin
            ptw_req_ready_i = 0; ptw_resp_valid_i = 0; pending = 0;
         end else begin
            if (resp_hs) begin ptw_resp_valid_i = 0; pending = 0; end
            if (req_hs) begin
               ptw_req_ready_i = 0; pending = 1; delay = $urandom_range(0, 3);
            end else ptw_req_ready_i = ptw_req_valid_o ? 1'($urandom_range(0, 1)) : 1'b0;
            if (pending && !ptw_resp_valid_i && !ptw_hold) begin
               if (delay == 0) begin
                  ptw_resp_valid_i = 1;
                  ptw_pte_i = pt.exists(walk_va[31:12]) ? pt[walk_va[31:12]] : 32'h0;
               end else delay--;
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [19:0] pool[12];
      int n;
      rst = 1; req_valid_i = 0; vaddr_i = 0; access_type_i = 0; asid_i = 0;
      resp_ready_i = 0; flush_valid_i = 0; flush_asid_only_i = 0; flush_asid_i = 0;
      m_reset();
      @(negedge clk);
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_ptw_req_valid", ptw_req_valid_o, 0);
      chk("rst_ptw_resp_ready", ptw_resp_ready_o, 0);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_hit_fault", {hit_o, fault_o}, 0);
      @(posedge clk); #1;
      rst = 0;

      // miss then hit
      pt[20'h12345] = 32'hABCDE003;
      access(32'h1234_5678, 0, 8'd5, 0, 1);
      access(32'h1234_5678, 0, 8'd5, 0, 1);
      // write to a read-only page, then again as a hit
      pt[20'h00400] = 32'h11111001;
      access(32'h0040_0ABC, 1, 8'd5, 0, 1);
      access(32'h0040_0ABC, 1, 8'd5, 0, 1);
      access(32'h0040_0ABC, 0, 8'd5, 0, 1);
      // invalid PTE: faults and walks again
      pt[20'h00777] = 32'h0;
      access(32'h0077_7010, 0, 8'd5, 0, 1);
      access(32'h0077_7010, 0, 8'd5, 0, 1);
      // flush colliding with a request: flush first, then the access walks
      access(32'h1234_5678, 0, 8'd5, 1, 1);

      // eviction: 9 pages into an empty TLB
      do_flush(0, 8'h0);
      for (int i = 0; i < 9; i++) begin
         pt[20'h50000 + 20'(i)] = {20'h60000 + 20'(i), 12'h003};
         access({20'h50000 + 20'(i), 12'h100}, 0, 8'd5, 0, 1);
      end
      for (int i = 1; i < 9; i++) access({20'h50000 + 20'(i), 12'h200}, 1, 8'd5, 0, 1);
      access({20'h50000, 12'h300}, 0, 8'd5, 0, 1);

`ifdef TLB_ASID_EN
      pt[20'h40001] = 32'h11111003;
      pt[20'h40002] = 32'h22222003;
      pt[20'h40003] = 32'h33333007;
      do_flush(0, 8'h0);
      access(32'h4000_1ABC, 0, 8'd3, 0, 1);
      access(32'h4000_2ABC, 0, 8'd5, 0, 1);
      access(32'h4000_3ABC, 0, 8'd3, 0, 1);
      do_flush(1, 8'd3);
      access(32'h4000_1ABC, 0, 8'd3, 0, 1);
      access(32'h4000_2ABC, 0, 8'd5, 0, 1);
      access(32'h4000_3ABC, 0, 8'd7, 0, 1);
`endif

      // randomised traffic over a small page pool
      for (int i = 0; i < 12; i++) begin
         pool[i] = 20'h70000 + 20'(i * 19);
         pt[pool[i]] = {20'($urandom), 9'h0, 3'($urandom_range(0, 7))};
      end
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 15) == 0)
            do_flush(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 8'd3 : 8'd5);
         access({pool[$urandom_range(0, 11)], 12'($urandom)}, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 8'd3 : 8'd5, 0, 1);
      end

      // reset while the walk is outstanding
      pt[20'h0ABCD] = 32'h44444003;
      ptw_hold = 1;
      access(32'h0ABC_D123, 0, 8'd5, 0, 0);
      n = 0;
      while (!ptw_resp_ready_o && n < 50) begin @(posedge clk); #1; n++; end
      if (!ptw_resp_ready_o) fail("reach_ptw_wait");
      rst = 1;
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      m_reset();
      @(negedge clk);
      chk("midrst_req_ready", req_ready_o, 1);
      chk("midrst_resp_valid", resp_valid_o, 0);
      chk("midrst_ptw_req_valid", ptw_req_valid_o, 0);
      chk("midrst_ptw_resp_ready", ptw_resp_ready_o, 0);
      chk("midrst_paddr", paddr_o, 0);
      chk("midrst_hit_fault", {hit_o, fault_o}, 0);
      @(posedge clk); #1;
      rst = 0; ptw_hold = 0;
      @(posedge clk); #1;
      access(32'h0ABC_D123, 0, 8'd5, 0, 1);

      repeat (5) @(posedge clk);
      chk("pending_responses", exp_q.size(), 0);
      chk("pending_walks", walk_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
